// File: rtl/pe_group_sched_pkg.sv
// Shared encodings for the pe_group2 sequencer: reset polarity, PE process
// codes, FSM state codes and the int8 requantisation clamp.
package pe_group_sched_pkg;

    localparam logic RST_ENABLE  = 1'b0;
    localparam logic RST_DISABLE = 1'b1;

    localparam logic [2:0] PROC_IDLE  = 3'b000;
    localparam logic [2:0] PROC_START = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FLUSH = 3'd4,
        ST_DONE  = 3'd5
    } sched_state_e;

    function automatic logic [7:0] sat8(input logic signed [31:0] v);
        if (v > 32'sd127)
            return 8'h7f;
        else if (v < -32'sd128)
            return 8'h80;
        else
            return v[7:0];
    endfunction

endpackage

// File: rtl/pe_group_acc.sv
// Pixel accumulator: sign-extends PE groupsums, sums taps_per_pix of them,
// then shifts, saturates to int8 and registers the output strobe.
module pe_group_acc
    import pe_group_sched_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cap_en,
    input  logic        cap_first,
    input  logic        cap_last,
    input  logic [18:0] pe_sum,
    input  logic [4:0]  shift,
    output logic        out_valid,
    output logic [7:0]  out_data
);

    logic signed [ACC_W-1:0] acc, acc_nxt, sum_ext, shifted;

    // The first tap loads instead of adding, so pixels need no clear cycle.
    always_comb begin
        sum_ext = {{(ACC_W-19){pe_sum[18]}}, pe_sum};
        acc_nxt = cap_first ? sum_ext : acc + sum_ext;
        shifted = acc_nxt >>> shift;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= cap_en && cap_last;
            if (cap_en)
                acc <= acc_nxt;
            if (cap_en && cap_last)
                out_data <= sat8({{(32-ACC_W){shifted[ACC_W-1]}}, shifted});
        end
    end

endmodule

// File: rtl/pe_group_sched.sv
// Run sequencer for one pe_group2 PE group: operand read streaming, PE
// pipeline hold/drain, per-pixel accumulation and output write-back.
module pe_group_sched
    import pe_group_sched_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int NUM_W  = 10,
    parameter int ACC_W  = 24,
    parameter int PE_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        layer,
    input  logic [NUM_W-1:0]  num_pix,
    input  logic [3:0]        taps_pix,
    input  logic [4:0]        shift,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [ADDR_W-1:0] out_base,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [2:0]        pe_process,
    output logic              pe_finish,
    input  logic              pe_wb_en,
    input  logic [18:0]       pe_sum,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [7:0]        out_data,
    output logic [3:0]        cur_layer,
    output logic              busy,
    output logic              done,
    output sched_state_e      state_dbg
);

    // Handshake: start is a level request sampled only in IDLE; done and
    // out_valid are one-cycle strobes with no back-pressure (no ready).
    localparam int CNT_W = NUM_W + 4;
    localparam int WD_W  = 4;

    sched_state_e      state, state_nxt;
    logic [3:0]        tap_n, rd_tap, cap_tap;
    logic [NUM_W-1:0]  num_q, rd_pix, cap_pix;
    logic [CNT_W-1:0]  rd_cnt, cap_cnt;
    logic [4:0]        shift_q;
    logic [ADDR_W-1:0] rd_base_q, out_base_q;
    logic [WD_W-1:0]   drain_cnt, wd_cnt;
    logic              rd_last, capturing, cap_en, cap_first, cap_last;

    assign rd_last   = (rd_tap == tap_n - 4'd1) && (rd_pix == num_q - NUM_W'(1));
    assign capturing = (state == ST_RUN) || (state == ST_DRAIN) || (state == ST_FLUSH);
    // rd_cnt ends the run equal to num_pix*tap_n, so it doubles as the total.
    assign cap_en    = pe_wb_en && capturing && (cap_cnt < rd_cnt);
    assign cap_first = (cap_tap == 4'd0);
    assign cap_last  = (cap_tap == tap_n - 4'd1);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = (num_pix == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (rd_last) state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_cnt == WD_W'(PE_LAT - 1)) state_nxt = ST_FLUSH;
            ST_FLUSH: if ((cap_cnt == rd_cnt) || (wd_cnt == WD_W'(PE_LAT + 1)))
                          state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            cur_layer  <= '0;
            tap_n      <= 4'd1;
            num_q      <= '0;
            shift_q    <= '0;
            rd_base_q  <= '0;
            out_base_q <= '0;
            rd_tap     <= '0;
            rd_pix     <= '0;
            rd_cnt     <= '0;
            cap_tap    <= '0;
            cap_pix    <= '0;
            cap_cnt    <= '0;
            drain_cnt  <= '0;
            wd_cnt     <= '0;
            pe_process <= PROC_IDLE;
            pe_finish  <= 1'b0;
            out_addr   <= '0;
        end else begin
            pe_process <= (state == ST_RUN) ? PROC_START : PROC_IDLE;
            pe_finish  <= (state == ST_DRAIN);
            case (state)
                ST_LOAD: begin
                    cur_layer  <= layer;
                    tap_n      <= (taps_pix == 4'd0) ? 4'd1 : taps_pix;
                    num_q      <= num_pix;
                    shift_q    <= shift;
                    rd_base_q  <= rd_base;
                    out_base_q <= out_base;
                    rd_tap     <= '0;
                    rd_pix     <= '0;
                    rd_cnt     <= '0;
                    cap_tap    <= '0;
                    cap_pix    <= '0;
                    cap_cnt    <= '0;
                    drain_cnt  <= '0;
                    wd_cnt     <= '0;
                end
                ST_RUN: begin
                    rd_cnt <= rd_cnt + CNT_W'(1);
                    if (rd_tap == tap_n - 4'd1) begin
                        rd_tap <= '0;
                        rd_pix <= rd_pix + NUM_W'(1);
                    end else begin
                        rd_tap <= rd_tap + 4'd1;
                    end
                end
                ST_DRAIN: drain_cnt <= drain_cnt + WD_W'(1);
                ST_FLUSH: wd_cnt <= wd_cnt + WD_W'(1);
                default: ;
            endcase
            if (cap_en) begin
                cap_cnt <= cap_cnt + CNT_W'(1);
                if (cap_last) begin
                    cap_tap  <= '0;
                    cap_pix  <= cap_pix + NUM_W'(1);
                    out_addr <= out_base_q + ADDR_W'(cap_pix);
                end else begin
                    cap_tap <= cap_tap + 4'd1;
                end
            end
        end
    end

    assign rd_en     = (state == ST_RUN);
    assign rd_addr   = rd_en ? rd_base_q + ADDR_W'(rd_cnt) : '0;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign state_dbg = state;

    pe_group_acc #(.ACC_W(ACC_W)) u_acc (
        .clk       (clk),
        .rst       (rst),
        .cap_en    (cap_en),
        .cap_first (cap_first),
        .cap_last  (cap_last),
        .pe_sum    (pe_sum),
        .shift     (shift_q),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

endmodule

// File: tb/tb_pe_group_sched.sv
// Directed bench for pe_group_sched with a behavioural 3-stage PE that
// advances only while Process=Start or FinishFlag is held.
module tb_pe_group_sched;
    import pe_group_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  layer = '0;
    logic [9:0]  num_pix = '0;
    logic [3:0]  taps_pix = '0;
    logic [4:0]  shift = '0;
    logic [9:0]  rd_base = '0;
    logic [9:0]  out_base = '0;
    logic        rd_en, pe_finish, pe_wb_en, out_valid, busy, done;
    logic [9:0]  rd_addr, out_addr;
    logic [2:0]  pe_process;
    logic [18:0] pe_sum;
    logic [7:0]  out_data;
    logic [3:0]  cur_layer;
    sched_state_e state_dbg;

    pe_group_sched dut (
        .clk(clk), .rst(rst), .start(start), .layer(layer), .num_pix(num_pix),
        .taps_pix(taps_pix), .shift(shift), .rd_base(rd_base), .out_base(out_base),
        .rd_en(rd_en), .rd_addr(rd_addr), .pe_process(pe_process), .pe_finish(pe_finish),
        .pe_wb_en(pe_wb_en), .pe_sum(pe_sum), .out_valid(out_valid), .out_addr(out_addr),
        .out_data(out_data), .cur_layer(cur_layer), .busy(busy), .done(done),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // behavioural PE pipeline
    logic        s1_v = 0, s2_v = 0, s3_v = 0, stray = 0;
    logic [18:0] s1_d = '0, s2_d = '0, s3_d = '0, beat_sum = '0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_v <= 0; s2_v <= 0; s3_v <= 0;
        end else if (pe_process == PROC_START || pe_finish) begin
            s1_v <= (pe_process == PROC_START); s1_d <= beat_sum;
            s2_v <= s1_v; s2_d <= s1_d;
            s3_v <= s2_v; s3_d <= s2_d;
        end
    end
    assign pe_wb_en = s3_v | stray;
    assign pe_sum   = s3_d;

    // scoreboard
    int n_checks = 0, n_fail = 0;
    logic [17:0] exp_q[$];
    int s_cyc = 0, rd_seen = 0, out_seen = 0, done_seen = 0;
    int first_rd_lat = -1, first_ov_lat = -1, done_lat = -1;
    logic [9:0] cur_rb = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (rd_en) begin
                logic [9:0] ea;
                ea = cur_rb + 10'(rd_seen);
                check("rd_addr", {22'd0, rd_addr}, {22'd0, ea});
                if (rd_seen == 0) first_rd_lat = cyc - s_cyc;
                rd_seen++;
            end
            if (out_valid) begin
                check("out_expected", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    logic [17:0] e;
                    e = exp_q.pop_front();
                    check("out_addr", {22'd0, out_addr}, {22'd0, e[17:8]});
                    check("out_data", {24'd0, out_data}, {24'd0, e[7:0]});
                end
                if (out_seen == 0) first_ov_lat = cyc - s_cyc;
                out_seen++;
            end
            if (done) begin
                done_seen++;
                done_lat = cyc - s_cyc;
            end
        end
    end

    typedef struct {
        int np; int taps; int sh; int sum; int rb; int ob; int lay;
        int reads; int outs; logic [7:0] data; int ov_lat; int done_lat;
    } vec_t;
    vec_t vecs[8];

    // driver
    task automatic start_run(input vec_t v, input bit push_exp);
        @(negedge clk);
        rd_seen = 0; out_seen = 0; done_seen = 0;
        first_rd_lat = -1; first_ov_lat = -1; done_lat = -1;
        cur_rb = 10'(v.rb);
        beat_sum = 19'(v.sum);
        if (push_exp)
            for (int i = 0; i < v.outs; i++) exp_q.push_back({10'(v.ob + i), v.data});
        num_pix = 10'(v.np); taps_pix = 4'(v.taps); shift = 5'(v.sh);
        rd_base = 10'(v.rb); out_base = 10'(v.ob); layer = 4'(v.lay);
        start = 1'b1;
        s_cyc = cyc;
    endtask

    task automatic run_vec(input vec_t v, input bit hold_start);
        bit got;
        start_run(v, 1'b1);
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        got = 0;
        for (int k = 0; k < 300 && !got; k++) begin
            if (done) got = 1;
            else @(negedge clk);
        end
        start = 1'b0;
        check("done_seen_in_budget", {31'd0, got}, 1);
        repeat (4) @(negedge clk);
        check("reads", rd_seen, v.reads);
        check("outputs", out_seen, v.outs);
        check("exp_q_empty", exp_q.size(), 0);
        check("first_rd_lat", first_rd_lat, (v.reads > 0) ? 2 : -1);
        check("first_ov_lat", first_ov_lat, v.ov_lat);
        check("done_lat", done_lat, v.done_lat);
        check("done_pulses", done_seen, 1);
        check("cur_layer", {28'd0, cur_layer}, v.lay);
        check("busy_after", {31'd0, busy}, 0);
        exp_q.delete();
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_rd_en"}, {31'd0, rd_en}, 0);
        check({tag, "_rd_addr"}, {22'd0, rd_addr}, 0);
        check({tag, "_pe_process"}, {29'd0, pe_process}, {29'd0, PROC_IDLE});
        check({tag, "_pe_finish"}, {31'd0, pe_finish}, 0);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 0);
        check({tag, "_out_addr"}, {22'd0, out_addr}, 0);
        check({tag, "_out_data"}, {24'd0, out_data}, 0);
        check({tag, "_cur_layer"}, {28'd0, cur_layer}, 0);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_done"}, {31'd0, done}, 0);
        check({tag, "_state"}, {29'd0, state_dbg}, {29'd0, ST_IDLE});
    endtask

    initial begin
        //        np taps sh  sum    rb    ob   lay rd outs data   ovl dl
        vecs[0] = '{1, 1, 0, 5,      10,   20,  3,  1, 1, 8'd5,   7, 8};
        vecs[1] = '{3, 2, 1, 100,    0,    100, 4,  6, 3, 8'd100, 8, 13};
        vecs[2] = '{2, 4, 0, 40000,  50,   60,  5,  8, 2, 8'h7f,  10, 15};
        vecs[3] = '{2, 4, 0, -40000, 50,   70,  6,  8, 2, 8'h80,  10, 15};
        vecs[4] = '{1, 1, 4, -17,    5,    7,   7,  1, 1, 8'hfe,  7, 8};
        vecs[5] = '{0, 3, 0, 1,      9,    9,   8,  0, 0, 8'd0,   -1, 2};
        vecs[6] = '{2, 0, 0, 7,      30,   40,  9,  2, 2, 8'd7,   7, 9};
        vecs[7] = '{2, 1, 0, 9,      1023, 1023, 2, 2, 2, 8'd9,   7, 9};

        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], 1'b0);

        // reset asserted mid-RUN after four reads
        begin
            vec_t r;
            bit got;
            r = '{3, 2, 0, 11, 100, 200, 12, 6, 3, 8'd22, 8, 13};
            start_run(r, 1'b0);
            @(negedge clk);
            start = 1'b0;
            got = 0;
            for (int k = 0; k < 50 && !got; k++) begin
                if (rd_seen >= 4) got = 1;
                else @(negedge clk);
            end
            check("mid_run_reads_in_budget", {31'd0, got}, 1);
            rst = 1'b0;
            @(posedge clk);
            #1;
            check_idle_zero("abort");
            repeat (4) @(negedge clk);
            check("abort_no_out", out_seen, 0);
            check("abort_no_done", done_seen, 0);
            rst = 1'b1;
            repeat (2) @(negedge clk);
            run_vec(vecs[0], 1'b0);
        end

        // start held through the run, then a stray wb strobe in IDLE
        begin
            vec_t h;
            h = '{1, 1, 0, 5, 0, 5, 1, 1, 1, 8'd5, 7, 8};
            run_vec(h, 1'b1);
            @(negedge clk);
            stray = 1'b1;
            @(negedge clk);
            stray = 1'b0;
            repeat (5) @(negedge clk);
            check("stray_no_out", out_seen, 1);
            check("stray_out_data", {24'd0, out_data}, 5);
            check("stray_no_reads", rd_seen, 1);
            check("stray_single_run", done_seen, 1);
            check("stray_busy", {31'd0, busy}, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
